// File: rtl/pipe_mdu_ctrl.sv
// pipe_mdu_ctrl -- multiply/divide unit controller for the 5-stage pipeline.
//
// Runs mult/multu through a latency-counted multiplier and div/divu through a
// 1-bit/cycle restoring divider. Owns the HI/LO registers, including mthi/mtlo
// writes, and raises a stall request while an op is in flight and the pipeline
// needs the unit or HI/LO.
//
// Ports
//   clk      in   1   clock, all state on rising edge
//   rst      in   1   synchronous active-high reset (discards an op in flight)
//   start    in   1   EXE issues mult/div this cycle (held while stall_o=1)
//   op       in   2   00 mult, 01 multu, 10 div, 11 divu
//   a        in  32   rs operand (dividend / multiplicand)
//   b        in  32   rt operand (divisor / multiplier)
//   mthi     in   1   write HI from wdata
//   mtlo     in   1   write LO from wdata
//   wdata    in  32   mthi/mtlo data
//   hilo_rd  in   1   ID decodes mfhi/mflo this cycle
//   hi       out 32   HI register
//   lo       out 32   LO register
//   busy     out  1   op in flight
//   done     out  1   one-cycle pulse, the cycle after HI/LO update from an op
//   stall_o  out  1   pipeline stall request (combinational)
module pipe_mdu_ctrl #(
    parameter int MUL_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    input  logic        hilo_rd,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        stall_o
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        done_q, done_d;
    logic        sgn_q, sgn_d;      // signed multiply
    logic        qs_q, qs_d;        // negate quotient in FIX
    logic        rs_q, rs_d;        // negate remainder in FIX
    logic        dz_q, dz_d;        // divide by zero: skip sign fix

    // Operand/working registers; no reset needed, always loaded on accept.
    // quo_q holds the multiplicand during MUL, dvs_q the multiplier.
    logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;

    logic [32:0]        shifted, trial;
    logic               ge;
    logic signed [63:0] mul_a, mul_b, prod;
    logic               sdiv;

    // Two's-complement negate when neg is set; used for magnitudes and sign fix.
    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

    always_comb begin
        shifted = {rem_q, quo_q[31]};
        trial   = shifted - {1'b0, dvs_q};
        // rem stays below the divisor, so a borrow into bit 32 means the
        // trial subtract went negative.
        ge      = ~trial[32];
        mul_a   = {{32{sgn_q & quo_q[31]}}, quo_q};
        mul_b   = {{32{sgn_q & dvs_q[31]}}, dvs_q};
        prod    = mul_a * mul_b;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        sgn_d   = sgn_q;
        qs_d    = qs_q;
        rs_d    = rs_q;
        dz_d    = dz_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        sdiv    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    // start wins over a same-cycle mthi/mtlo
                    sgn_d = ~op[0];
                    if (!op[1]) begin
                        state_d = S_MUL;
                        cnt_d   = 5'(MUL_LAT - 1);
                        quo_d   = a;
                        dvs_d   = b;
                    end else begin
                        state_d = S_DIV;
                        cnt_d   = 5'd31;
                        dz_d    = (b == 32'd0);
                        // With a zero divisor the raw dividend is shifted through,
                        // which leaves rem=a and quo=all ones.
                        sdiv    = ~op[0] & (b != 32'd0);
                        quo_d   = cond_neg(a, sdiv & a[31]);
                        dvs_d   = cond_neg(b, sdiv & b[31]);
                        rem_d   = 32'd0;
                        qs_d    = ~op[0] & (a[31] ^ b[31]);
                        rs_d    = ~op[0] & a[31];
                    end
                end else begin
                    if (mthi) hi_d = wdata;
                    if (mtlo) lo_d = wdata;
                end
            end
            S_MUL: begin
                if (cnt_q == 5'd0) begin
                    hi_d    = prod[63:32];
                    lo_d    = prod[31:0];
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            S_DIV: begin
                rem_d = ge ? trial[31:0] : shifted[31:0];
                quo_d = {quo_q[30:0], ge};
                if (cnt_q == 5'd0) state_d = S_FIX;
                else               cnt_d   = cnt_q - 5'd1;
            end
            S_FIX: begin
                lo_d    = dz_q ? quo_q : cond_neg(quo_q, qs_q);
                hi_d    = dz_q ? rem_q : cond_neg(rem_q, rs_q);
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
            sgn_q   <= 1'b0;
            qs_q    <= 1'b0;
            rs_q    <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            sgn_q   <= sgn_d;
            qs_q    <= qs_d;
            rs_q    <= rs_d;
            dz_q    <= dz_d;
        end
    end

    always_ff @(posedge clk) begin
        rem_q <= rem_d;
        quo_q <= quo_d;
        dvs_q <= dvs_d;
    end

    assign hi      = hi_q;
    assign lo      = lo_q;
    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign stall_o = busy & (start | hilo_rd | mthi | mtlo);

endmodule

// File: tb/tb_pipe_mdu_ctrl.sv
module tb_pipe_mdu_ctrl;
    localparam int MUL_LAT = 3;

    logic        clk = 1'b0;
    logic        rst, start, mthi, mtlo, hilo_rd;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic [31:0] hi, lo;
    logic        busy, done, stall_o;

    int checks = 0;
    int errors = 0;

    pipe_mdu_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .hilo_rd(hilo_rd),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .stall_o(stall_o)
    );

    always #5 clk = ~clk;

    // Architectural result of one op, from plain 64-bit arithmetic.
    function automatic void ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                      output logic [31:0] h, output logic [31:0] l);
        longint      sp, q, r;
        logic [63:0] up;
        h = 32'd0; l = 32'd0;
        case (o)
            2'b00: begin sp = longint'($signed(x)) * longint'($signed(y)); {h, l} = sp; end
            2'b01: begin up = {32'd0, x} * {32'd0, y}; {h, l} = up; end
            default: begin
                if (y == 32'd0) begin
                    h = x; l = 32'hFFFF_FFFF;
                end else if (o == 2'b11) begin
                    l = x / y; h = x % y;
                end else begin
                    q = longint'($signed(x)) / longint'($signed(y));
                    r = longint'($signed(x)) % longint'($signed(y));
                    l = q[31:0]; h = r[31:0];
                end
            end
        endcase
    endfunction

    // Issue one op and follow it to its done cycle; returns at the negedge of
    // the first cycle with busy low. lat counts cycles seen with busy high.
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output logic dn, output logic early);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; early = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
            if (done) early = 1'b1;
            lat++;
        end
        dn = done;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (hi !== 32'd0)   begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
        checks++; if (lo !== 32'd0)   begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall_o); end
        rst = 1'b0;
    endtask

    task automatic test_mul_directed;
        int lat; logic dn, early;
        do_op(2'b01, 32'hFFFF_FFFF, 32'd2, lat, dn, early);
        checks++; if (hi !== 32'h1) begin errors++; $display("FAIL multu_hi got %h want 00000001", hi); end
        checks++; if (lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_lo got %h want fffffffe", lo); end
        checks++; if (lat !== MUL_LAT) begin errors++; $display("FAIL multu_lat got %0d want %0d", lat, MUL_LAT); end
        checks++; if (dn !== 1'b1 || early !== 1'b0) begin errors++; $display("FAIL multu_done got %b early %b want 1/0", dn, early); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse_width got %b want 0", done); end
        do_op(2'b00, -32'sd3, 32'd5, lat, dn, early);
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", hi); end
        checks++; if (lo !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mult_lo got %h want fffffff1", lo); end
    endtask

    task automatic test_div_directed;
        logic [31:0] ta [4] = '{-32'sd7, 32'd100, 32'h1234, 32'h8000_0000};
        logic [31:0] tb [4] = '{32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF};
        logic [1:0]  to [4] = '{2'b10, 2'b11, 2'b10, 2'b10};
        logic [31:0] eh [4] = '{32'hFFFF_FFFF, 32'd2, 32'h1234, 32'd0};
        logic [31:0] el [4] = '{32'hFFFF_FFFD, 32'd14, 32'hFFFF_FFFF, 32'h8000_0000};
        int lat; logic dn, early;
        for (int i = 0; i < 4; i++) begin
            do_op(to[i], ta[i], tb[i], lat, dn, early);
            checks++; if (hi !== eh[i]) begin errors++; $display("FAIL div_dir%0d_hi got %h want %h", i, hi, eh[i]); end
            checks++; if (lo !== el[i]) begin errors++; $display("FAIL div_dir%0d_lo got %h want %h", i, lo, el[i]); end
            checks++; if (lat !== 33) begin errors++; $display("FAIL div_dir%0d_lat got %0d want 33", i, lat); end
            checks++; if (dn !== 1'b1 || early !== 1'b0) begin errors++; $display("FAIL div_dir%0d_done got %b early %b", i, dn, early); end
        end
    endtask

    task automatic test_random;
        int lat; logic dn, early;
        logic [1:0] o; logic [31:0] x, y, eh, el;
        for (int i = 0; i < 30; i++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            case ($urandom_range(0, 7))
                0:       y = 32'd0;
                1:       y = $urandom_range(1, 15);
                2:       y = -($urandom_range(1, 15));
                default: y = $urandom;
            endcase
            ref_model(o, x, y, eh, el);
            do_op(o, x, y, lat, dn, early);
            checks++; if (hi !== eh) begin errors++; $display("FAIL rand%0d_hi op %0d a %h b %h got %h want %h", i, o, x, y, hi, eh); end
            checks++; if (lo !== el) begin errors++; $display("FAIL rand%0d_lo op %0d a %h b %h got %h want %h", i, o, x, y, lo, el); end
            checks++; if (lat !== (o[1] ? 33 : MUL_LAT)) begin errors++; $display("FAIL rand%0d_lat got %0d want %0d", i, lat, o[1] ? 33 : MUL_LAT); end
            checks++; if (dn !== 1'b1 || early !== 1'b0) begin errors++; $display("FAIL rand%0d_done got %b early %b", i, dn, early); end
        end
    endtask

    task automatic test_mthi_mtlo;
        int n;
        @(posedge clk); #1;
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5_0001; hilo_rd = 1'b1;
        #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL idle_stall got %b want 0", stall_o); end
        @(posedge clk); #1;
        hilo_rd = 1'b0; mthi = 1'b0;
        wdata = 32'h0000_BEEF;
        checks++; if (hi !== 32'hA5A5_0001) begin errors++; $display("FAIL mthi_both got %h want a5a50001", hi); end
        checks++; if (lo !== 32'hA5A5_0001) begin errors++; $display("FAIL mtlo_both got %h want a5a50001", lo); end
        @(posedge clk); #1;
        mtlo = 1'b0;
        checks++; if (lo !== 32'h0000_BEEF || hi !== 32'hA5A5_0001) begin errors++; $display("FAIL mtlo_only got hi %h lo %h want a5a50001/0000beef", hi, lo); end
        start = 1'b1; op = 2'b01; a = 32'd2; b = 32'd3; mthi = 1'b1; wdata = 32'hDEAD_0000;
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0;
        checks++; if (hi !== 32'hA5A5_0001 || busy !== 1'b1) begin errors++; $display("FAIL start_beats_mthi got hi %h busy %b want a5a50001/1", hi, busy); end
        n = 0;
        while (busy && n < 100) begin @(negedge clk); n++; end
        checks++; if (hi !== 32'd0 || lo !== 32'd6) begin errors++; $display("FAIL start_mthi_result got %h_%h want 0_6", hi, lo); end
    endtask

    task automatic test_back_to_back;
        int n; logic stall_bad;
        start = 1'b1; op = 2'b10; a = -32'sd100; b = 32'd7;
        @(posedge clk); #1;
        op = 2'b01; a = 32'h0001_0000; b = 32'h30; hilo_rd = 1'b1;
        n = 0; stall_bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
            if (!stall_o) stall_bad = 1'b1;
            n++;
        end
        checks++; if (stall_bad !== 1'b0 || n !== 33) begin errors++; $display("FAIL stall_during_div got bad %b cycles %0d want 0/33", stall_bad, n); end
        checks++; if (stall_o !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL stall_release got stall %b done %b want 0/1", stall_o, done); end
        checks++; if (hi !== 32'hFFFF_FFFE || lo !== 32'hFFFF_FFF2) begin errors++; $display("FAIL b2b_div got %h_%h want fffffffe_fffffff2", hi, lo); end
        @(posedge clk); #1;
        start = 1'b0; hilo_rd = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy %b want 1", busy); end
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        checks++; if (n !== MUL_LAT) begin errors++; $display("FAIL b2b_mul_lat got %0d want %0d", n, MUL_LAT); end
        checks++; if (hi !== 32'd0 || lo !== 32'h0030_0000) begin errors++; $display("FAIL b2b_mul got %h_%h want 0_00300000", hi, lo); end
    endtask

    task automatic test_reset_mid_op;
        logic saw_done;
        start = 1'b1; op = 2'b11; a = 32'd1000; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", busy); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || done !== 1'b0) begin errors++; $display("FAIL mid_reset got busy %b hi %h lo %h done %b want 0/0/0/0", busy, hi, lo, done); end
        saw_done = 1'b0;
        repeat (40) begin @(negedge clk); if (done || busy) saw_done = 1'b1; end
        checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL mid_reset_quiet got %b want 0", saw_done); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
        mthi = 1'b0; mtlo = 1'b0; wdata = 32'd0; hilo_rd = 1'b0;
        test_reset();
        test_mul_directed();
        test_div_directed();
        test_random();
        test_mthi_mtlo();
        test_back_to_back();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
